// File: rtl/morph_filter_3x3_if.sv
// Pixel stream bundle between the binarizer, the morphology filter and the display path.
// The master side feeds bits/pixels and observes results; the slave side is the filter.
interface morph_filter_3x3_if #(
    parameter int unsigned PIX_W = 24
) ();
    logic             in_valid;
    logic             in_ready;
    logic             in_sof;
    logic             in_bit;
    logic [PIX_W-1:0] in_pixel;
    logic             out_valid;
    logic [PIX_W-1:0] out_pixel;
    logic             out_mask;
    logic             frame_end;

    modport master (
        output in_valid, in_sof, in_bit, in_pixel,
        input  in_ready, out_valid, out_pixel, out_mask, frame_end
    );

    modport slave (
        input  in_valid, in_sof, in_bit, in_pixel,
        output in_ready, out_valid, out_pixel, out_mask, frame_end
    );
endinterface

// File: rtl/morph_filter_3x3.sv
// Streaming 3x3 binary erosion/dilation (square or cross kernel) with line buffers;
// marked pixels are replaced by MARK_COLOR, others pass the delayed original RGB.
module morph_filter_3x3 #(
    parameter int unsigned      IMG_WIDTH  = 720,
    parameter int unsigned      IMG_HEIGHT = 480,
    parameter int unsigned      PIX_W      = 24,
    parameter logic [PIX_W-1:0] MARK_COLOR = PIX_W'(24'hFF0000)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              mode,
    input  logic              shape,
    morph_filter_3x3_if.slave bus
);
    localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned FL_W  = $clog2(IMG_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t             state;
    logic               in_ready_q;
    logic [COL_W-1:0]   in_col, cen_col, win_col, ptr;
    logic [ROW_W-1:0]   in_row, cen_row, win_row;
    logic [FL_W-1:0]    fl_cnt;
    logic               win_valid, win_last, mode_q, shape_q;
    logic [2:0][2:0]    win;
    logic [PIX_W-1:0]   rgb_right, rgb_ctr;
    logic               lb1 [IMG_WIDTH];
    logic               lb2 [IMG_WIDTH];
    logic [PIX_W-1:0]   lbp [IMG_WIDTH];
    logic               out_valid_q, out_mask_q, frame_end_q;
    logic [PIX_W-1:0]   out_pixel_q;

    logic accept_c, sof_c, shift_c, kill_c, produce_c, last_beat_c, emit_c;
    logic new_bit_c, k_res_c;
    logic [PIX_W-1:0] new_pix_c;

    assign accept_c    = bus.in_valid & in_ready_q;
    assign sof_c       = accept_c & bus.in_sof;
    assign kill_c      = sof_c & (state == STREAM);
    assign shift_c     = (accept_c & ((state == STREAM) | bus.in_sof)) | (state == FLUSH);
    assign last_beat_c = (in_row == ROW_W'(IMG_HEIGHT - 1)) & (in_col == COL_W'(IMG_WIDTH - 1));
    // A centre exists once the newest index reaches IMG_WIDTH+1 (row 1, col 1)
    assign produce_c   = (state == FLUSH) |
                         ((state == STREAM) & accept_c & ~bus.in_sof &
                          ((in_row > ROW_W'(1)) | ((in_row == ROW_W'(1)) & (in_col != '0))));
    assign new_bit_c   = (state == FLUSH) ? 1'b0 : bus.in_bit;
    assign new_pix_c   = (state == FLUSH) ? '0 : bus.in_pixel;
    assign emit_c      = win_valid & ~kill_c;

    // Line buffers: contents never reset, out-of-image taps are masked by position
    always_ff @(posedge clock) begin
        if (shift_c) begin
            lb1[ptr] <= new_bit_c;
            lb2[ptr] <= lb1[ptr];
            lbp[ptr] <= new_pix_c;
        end
    end

    // Window: column 2 is newest; row 0 is two lines up, row 2 is the current line
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= '0;
            win       <= '0;
            rgb_right <= '0;
            rgb_ctr   <= '0;
        end else if (shift_c) begin
            ptr <= (ptr == COL_W'(IMG_WIDTH - 1)) ? '0 : ptr + COL_W'(1);
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2[ptr];
            win[1][2] <= lb1[ptr];
            win[2][2] <= new_bit_c;
            rgb_right <= lbp[ptr];
            rgb_ctr   <= rgb_right;
        end
    end

    // Control FSM plus input and centre position bookkeeping
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
            in_col     <= '0;
            in_row     <= '0;
            cen_col    <= '0;
            cen_row    <= '0;
            win_col    <= '0;
            win_row    <= '0;
            fl_cnt     <= '0;
            win_valid  <= 1'b0;
            win_last   <= 1'b0;
            mode_q     <= 1'b0;
            shape_q    <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            if (produce_c) begin
                win_valid <= 1'b1;
                win_col   <= cen_col;
                win_row   <= cen_row;
                win_last  <= (cen_row == ROW_W'(IMG_HEIGHT - 1)) & (cen_col == COL_W'(IMG_WIDTH - 1));
                if (cen_col == COL_W'(IMG_WIDTH - 1)) begin
                    cen_col <= '0;
                    cen_row <= cen_row + ROW_W'(1);
                end else begin
                    cen_col <= cen_col + COL_W'(1);
                end
            end
            if (sof_c) begin
                state   <= STREAM;
                mode_q  <= mode;
                shape_q <= shape;
                in_col  <= COL_W'(1);
                in_row  <= '0;
                cen_col <= '0;
                cen_row <= '0;
            end else begin
                case (state)
                    STREAM: begin
                        if (accept_c) begin
                            if (in_col == COL_W'(IMG_WIDTH - 1)) begin
                                in_col <= '0;
                                in_row <= in_row + ROW_W'(1);
                            end else begin
                                in_col <= in_col + COL_W'(1);
                            end
                            if (last_beat_c) begin
                                state      <= FLUSH;
                                in_ready_q <= 1'b0;
                                fl_cnt     <= '0;
                            end
                        end
                    end
                    FLUSH: begin
                        fl_cnt <= fl_cnt + FL_W'(1);
                        if (fl_cnt == FL_W'(IMG_WIDTH)) begin
                            state      <= IDLE;
                            in_ready_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Kernel: taps outside the image are skipped, which equals using the neutral value
    logic tap_in, tap_act, k_and, k_or;
    always_comb begin
        tap_in  = 1'b0;
        tap_act = 1'b0;
        k_and   = 1'b1;
        k_or    = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                tap_in  = !(((r == 0) && (win_row == '0)) ||
                            ((r == 2) && (win_row == ROW_W'(IMG_HEIGHT - 1))) ||
                            ((c == 0) && (win_col == '0)) ||
                            ((c == 2) && (win_col == COL_W'(IMG_WIDTH - 1))));
                tap_act = !shape_q || (r == 1) || (c == 1);
                if (tap_in && tap_act) begin
                    k_and = k_and & win[r][c];
                    k_or  = k_or  | win[r][c];
                end
            end
        end
        k_res_c = mode_q ? k_or : k_and;
    end

    // Output register stage
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_mask_q  <= 1'b0;
            frame_end_q <= 1'b0;
            out_pixel_q <= '0;
        end else begin
            out_valid_q <= emit_c;
            out_mask_q  <= emit_c & k_res_c;
            frame_end_q <= emit_c & win_last;
            out_pixel_q <= emit_c ? (k_res_c ? MARK_COLOR : rgb_ctr) : '0;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_mask  = out_mask_q;
    assign bus.frame_end = frame_end_q;
    assign bus.out_pixel = out_pixel_q;
endmodule

// File: doc/morph_filter_3x3.md
# morph_filter_3x3

Streaming 3x3 binary morphology filter with on-chip line buffers and run-time mode select (erosion or dilation, square or cross kernel). It takes a raster-order stream of binarized bits plus original RGB pixels from the thresholding stage and emits one RGB pixel per input pixel. Pixels whose kernel result is 1 are replaced by a marker colour. It sits between the binarizer and the centroid/display path and supplies its own row/column bookkeeping and end-of-frame signalling.

## Interface
- IMG_WIDTH, 720: pixels per line.
- IMG_HEIGHT, 480: lines per frame (frame = IMG_WIDTH*IMG_HEIGHT pixels).
- PIX_W, 24: RGB pixel width.
- MARK_COLOR, 24'hFF0000: output colour for pixels with kernel result 1.
- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_sof  in  1  first pixel of frame, qualified by in_valid.
- in_bit  in  1  binarized value of the pixel.
- in_pixel  in  PIX_W  original RGB of the pixel.
- mode  in  1  0 = erosion (AND), 1 = dilation (OR); sampled on accepted in_sof.
- shape  in  1  0 = 3x3 square (9 taps), 1 = cross (centre + 4 orthogonal taps); sampled on accepted in_sof.
- out_valid  out  1  output beat, no backpressure.
- out_pixel  out  PIX_W  MARK_COLOR if kernel result 1, else the delayed centre in_pixel.
- out_mask  out  1  kernel result.
- frame_end  out  1  one-cycle pulse coincident with the last out_valid of a frame.

## Operation
- An accepted beat means in_valid & in_ready.
- Storage:
  - two bit line buffers, depth IMG_WIDTH;
  - one RGB line buffer, depth IMG_WIDTH;
  - a 3x3 bit window plus RGB centre registers.
  - The window centre lags the newest accepted pixel by IMG_WIDTH+1 positions.
- Input row/col counters advance per accepted beat. Col wraps at IMG_WIDTH-1, incrementing row.
- Border handling: taps outside the image use the neutral value, 1 for erosion and 0 for dilation. Neutral applies to the left/right column wrap, to row -1, and to row IMG_HEIGHT.
- States:
  - IDLE: in_ready=1. Beats without in_sof are dropped. An accepted in_sof latches mode and shape, clears counters, and enters STREAM.
  - STREAM: in_ready=1. Each accepted beat shifts the window.
    - Once the input index is at least IMG_WIDTH+1, one output is produced for centre index = input index - (IMG_WIDTH+1).
    - The beat at index IMG_WIDTH*IMG_HEIGHT-1 moves the block to FLUSH.
    - An accepted in_sof restarts the frame: counters are cleared, the pending window is discarded, mode and shape are re-latched, and no frame_end is issued for the aborted frame.
  - FLUSH: in_ready=0. Each cycle injects one neutral beat and produces one output, for IMG_WIDTH+1 cycles, until the last centre pixel is emitted. It then returns to IDLE.
- Output count per completed frame is exactly IMG_WIDTH*IMG_HEIGHT.
- Kernel result:
  - erosion: AND of the active taps.
  - dilation: OR of the active taps.

## Timing
- Reset value of every output:
  - out_valid, out_mask, frame_end = 0;
  - out_pixel = 0;
  - in_ready = 1 (state IDLE).
- Reset also clears the counters and window. Line buffer contents need not be cleared, because the border logic masks them.
- Latency: the output for centre pixel k is registered one cycle after the accepted beat (or flush cycle) carrying pixel k+IMG_WIDTH+1.
- Input bubbles (in_valid=0) stall the pipeline. They produce no out_valid and do not corrupt the window.
- frame_end asserts in the same cycle as the final out_valid. The first cycle after that flush ends has in_ready=1.
- reset_n asserted mid-frame or mid-FLUSH returns the block to IDLE immediately, with no further outputs.

## Test plan
- W=8,H=4, erosion/square, all in_bit=1, in_pixel=24'h000010 -> 32 outputs, all 24'hFF0000, out_mask=1. frame_end is on output 32. The first output comes 1 cycle after beat 10.
- Same frame, erosion/square, single in_bit=0 at (row2,col3) -> out_mask=0 exactly at rows1-3, cols2-4 (9 pixels); those pixels pass in_pixel unchanged.
- Dilation/cross, all zeros except 1 at (1,1) -> out_mask=1 only at (1,1),(0,1),(2,1),(1,0),(1,2). Repeating with square gives the full 3x3 set around (1,1).
- Random in_valid bubbles (~40%) on frame 2 -> output sequence identical to the gap-free run, and out_valid count = 32.
- in_sof re-asserted at beat 17 of a frame -> no frame_end for the aborted frame. The new frame completes with 32 outputs using the newly latched mode.
- reset_n pulsed low during FLUSH -> outputs drop to 0 asynchronously, in_ready=1 after release, and the next in_sof frame processes correctly.
